// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer.
// Covers opcodes, ALU codes, the sequencer state encoding and the decoded-instruction record.
package cpu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_STA = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPND   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // is_cond qualifies is_jump: the jump is taken only when zero_flag is set.
  typedef struct packed {
    logic       two_byte;
    logic       is_jump;
    logic       is_cond;
    logic       is_halt;
    logic       mem_write;
    logic       acc_write;
    logic       acc_src;
    logic [1:0] alu_op;
  } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder for the CPU sequencer.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP: ;
      OP_LDA: begin
        dec.two_byte  = 1'b1;
        dec.acc_write = 1'b1;
        dec.acc_src   = 1'b1;
      end
      OP_STA: begin
        dec.two_byte  = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_ADD: begin
        dec.two_byte  = 1'b1;
        dec.acc_write = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_SUB: begin
        dec.two_byte  = 1'b1;
        dec.acc_write = 1'b1;
        dec.alu_op    = ALU_SUB;
      end
      OP_JMP: begin
        dec.two_byte = 1'b1;
        dec.is_jump  = 1'b1;
      end
      OP_JZ: begin
        dec.two_byte = 1'b1;
        dec.is_jump  = 1'b1;
        dec.is_cond  = 1'b1;
      end
      OP_HLT: dec.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM: drives the PC, the shared memory port and
// the accumulator/ALU strobes; st_dbg exposes the current state.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] RST_VEC = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              pc_up,
  output logic              pc_jump,
  output logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        alu_op,
  output logic              acc_we,
  output logic              acc_src,
  input  logic              zero_flag,
  output logic              halted,
  output state_e            st_dbg
);

  state_e            st_q, st_d;
  logic [2:0]        ir_q, ir_d;
  logic [ADDR_W-1:0] opnd_q, opnd_d;
  dec_t              dec;

  cpu_decode u_decode (
    .opcode (ir_q),
    .dec    (dec)
  );

  assign st_dbg = st_q;

  // Memory handshake: mem_req with mem_addr/mem_we is held steady from the
  // request until the cycle mem_ack=1; the access completes at that edge.
  always_comb begin
    st_d      = st_q;
    ir_d      = ir_q;
    opnd_d    = opnd_q;
    pc_up     = 1'b0;
    pc_jump   = 1'b0;
    pc_target = opnd_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_value;
    acc_we    = 1'b0;
    acc_src   = 1'b0;
    alu_op    = ALU_PASS;
    halted    = 1'b0;
    case (st_q)
      ST_BOOT: begin
        pc_jump   = 1'b1;
        pc_target = RST_VEC;
        st_d      = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d  = mem_rdata[DATA_W-1 -: 3];
          pc_up = 1'b1;
          st_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.is_halt)       st_d = ST_HALT;
        else if (dec.two_byte) st_d = ST_OPND;
        else                   st_d = ST_FETCH;
      end
      ST_OPND: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          opnd_d = mem_rdata[ADDR_W-1:0];
          pc_up  = 1'b1;
          st_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec.is_jump && (!dec.is_cond || zero_flag)) begin
          pc_jump   = 1'b1;
          pc_target = opnd_q;
        end
        st_d = dec.is_jump ? ST_FETCH : ST_MEM;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = dec.mem_write;
        mem_addr = opnd_q;
        if (mem_ack) begin
          acc_we  = dec.acc_write;
          acc_src = dec.acc_src;
          alu_op  = dec.alu_op;
          st_d    = ST_FETCH;
        end
      end
      ST_HALT: halted = 1'b1;
      default: st_d = ST_BOOT;
    endcase
    // Strobes are silenced while reset is held so an abandoned access never
    // completes or bumps the PC.
    if (!rst) begin
      pc_up   = 1'b0;
      pc_jump = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      acc_we  = 1'b0;
      acc_src = 1'b0;
      alu_op  = ALU_PASS;
      halted  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q   <= ST_BOOT;
      ir_q   <= '0;
      opnd_q <= '0;
    end else begin
      st_q   <= st_d;
      ir_q   <= ir_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level trace model,
// memory responder with programmable wait states, and a bench-side PC.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pc_value;
  logic       pc_up, pc_jump;
  logic [7:0] pc_target;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic [1:0] alu_op;
  logic       acc_we, acc_src;
  logic       zero_flag = 1'b0;
  logic       halted;
  state_e     st_dbg;

  cpu_sequencer #(.ADDR_W(8), .DATA_W(8), .RST_VEC(8'h00)) dut (
    .clk(clk), .rst(rst), .pc_value(pc_value),
    .pc_up(pc_up), .pc_jump(pc_jump), .pc_target(pc_target),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_op(alu_op), .acc_we(acc_we), .acc_src(acc_src),
    .zero_flag(zero_flag), .halted(halted), .st_dbg(st_dbg)
  );

  // clock / environment
  always #5 clk = ~clk;

  logic [7:0] pc_q = 8'h55;
  always @(posedge clk) begin
    if (pc_jump)    pc_q <= pc_target;
    else if (pc_up) pc_q <= pc_q + 8'd1;
  end
  assign pc_value = pc_q;

  logic [7:0]  mem [256];
  int          wait_q[$];
  int          model_wq[$];
  logic [24:0] exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          trace_len;

  // {pc_up, pc_jump, pc_target, mem_req, mem_we, mem_addr, acc_we, acc_src, alu_op, halted}
  function automatic logic [24:0] vec(input logic up, input logic jump, input logic [7:0] tgt,
                                      input logic req, input logic we, input logic [7:0] addr,
                                      input logic awe, input logic asrc, input logic [1:0] op,
                                      input logic hlt);
    return {up, jump, tgt, req, we, addr, awe, asrc, op, hlt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // model: one memory access = wait cycles, then the ack cycle with its strobes
  task automatic emit_acc(input logic [7:0] addr, input logic we, input logic up,
                          input logic awe, input logic asrc, input logic [1:0] op);
    int w;
    w = (model_wq.size() > 0) ? model_wq.pop_front() : 0;
    repeat (w) exp_q.push_back(vec(1'b0, 1'b0, 8'h00, 1'b1, we, addr, 1'b0, 1'b0, 2'b00, 1'b0));
    exp_q.push_back(vec(up, 1'b0, 8'h00, 1'b1, we, addr, awe, asrc, op, 1'b0));
  endtask

  // model: interpret the program from the restart address and list expected cycles
  task automatic build_trace(input logic zf, input int halt_cycles);
    logic [7:0] pc, a;
    logic [2:0] op;
    bit         done;
    model_wq = wait_q;
    done = 0;
    exp_q.push_back(vec(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0));
    pc = 8'h00;
    for (int n = 0; n < 50 && !done; n++) begin
      emit_acc(pc, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      op = mem[pc][7:5];
      pc = pc + 8'd1;
      exp_q.push_back(25'd0);
      if (op == 3'd7) begin
        repeat (halt_cycles) exp_q.push_back(vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1));
        done = 1;
      end else if (op != 3'd0) begin
        a = mem[pc];
        emit_acc(pc, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        pc = pc + 8'd1;
        if (op == 3'd5 || (op == 3'd6 && zf)) begin
          exp_q.push_back(vec(1'b0, 1'b1, a, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0));
          pc = a;
        end else if (op == 3'd6) begin
          exp_q.push_back(25'd0);
        end else begin
          exp_q.push_back(25'd0);
          emit_acc(a, op == 3'd2, 1'b0, op != 3'd2, op == 3'd1,
                   (op == 3'd3) ? 2'b01 : (op == 3'd4) ? 2'b10 : 2'b00);
        end
      end
    end
    trace_len = exp_q.size();
  endtask

  // memory responder plus the per-cycle compare
  bit busy = 0;
  int cnt = 0;
  int cur_wait = 0;
  logic [24:0] act_v, exp_v;
  always @(negedge clk) begin
    cyc++;
    if (rst && mem_req) begin
      if (!busy) begin
        busy = 1;
        cnt = 0;
        cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      end
      mem_ack   = (cnt == cur_wait);
      mem_rdata = mem[mem_addr];
      if (mem_ack) busy = 0;
      else cnt++;
    end else begin
      if (!rst) busy = 0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom_range(0, 255));
    end
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {pc_up, pc_jump, pc_jump ? pc_target : 8'h00, mem_req,
               mem_req ? mem_we : 1'b0, mem_req ? mem_addr : 8'h00,
               acc_we, acc_src, alu_op, halted};
      n_total++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle%0d outputs act=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  end

  // driver tasks (called at posedge+2)
  task automatic reset_dut();
    rst = 1'b0;
    exp_q.push_back(25'd0);
    exp_q.push_back(25'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", 32'(st_dbg), 32'(ST_BOOT));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL %s timeout left=%0d", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_case(input string name, input logic zf, input int halt_cycles,
                          input int exp_len, input logic [7:0] exp_pc);
    zero_flag = zf;
    build_trace(zf, halt_cycles);
    chk({name, "_len"}, 32'(trace_len), 32'(exp_len));
    drain(name);
    chk({name, "_pc"}, 32'(pc_q), 32'(exp_pc));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    wait_q.delete();
  endtask

  initial begin
    clear_mem();
    @(posedge clk);
    #2;

    // NOP; JMP 05; HLT at 05 (random acks during halt)
    mem[0] = 8'h00; mem[1] = 8'hA0; mem[2] = 8'h05; mem[5] = 8'hE0;
    reset_dut();
    run_case("nop_jmp", 1'b0, 8, 17, 8'h06);

    // JZ 10 twice, zero_flag low: falls through to HLT at 04
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h10; mem[2] = 8'hC0; mem[3] = 8'h10;
    mem[4] = 8'hE0; mem[8'h10] = 8'hE0;
    reset_dut();
    run_case("jz_fall", 1'b0, 4, 15, 8'h05);
    // same program, zero_flag high: first JZ taken to 10
    reset_dut();
    run_case("jz_take", 1'b1, 4, 11, 8'h11);

    // LDA 20 with three wait cycles on the data access
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h20; mem[2] = 8'hE0; mem[8'h20] = 8'h3C;
    wait_q = '{0, 0, 3};
    reset_dut();
    run_case("lda_wait", 1'b0, 4, 15, 8'h03);

    // STA 30; SUB 30; ADD 30; HLT with scattered waits
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h30; mem[2] = 8'h80; mem[3] = 8'h30;
    mem[4] = 8'h60; mem[5] = 8'h30; mem[6] = 8'hE0;
    wait_q = '{1, 0, 2, 0, 1, 1};
    reset_dut();
    run_case("sta_sub_add", 1'b0, 4, 27, 8'h07);

    // reset abandons a stalled fetch; PC must not advance for it
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'hA0; mem[2] = 8'h05; mem[5] = 8'hE0;
    wait_q = '{5};
    reset_dut();
    exp_q.push_back(vec(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0));
    repeat (3) exp_q.push_back(vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0));
    drain("abort_pre");
    chk("abort_pc_before", 32'(pc_q), 32'h00);
    reset_dut();
    chk("abort_pc_after", 32'(pc_q), 32'h00);
    wait_q.delete();
    run_case("after_abort", 1'b0, 8, 17, 8'h06);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
